// File: rtl/flow_lookup_ctrl_if.sv
// Flow lookup controller bus: key strobe, config write port, result and stats.
interface flow_lookup_ctrl_if #(
  parameter int KEY_W = 128,
  parameter int ACT_W = 16,
  parameter int IDX_W = 8
);
  logic [KEY_W-1:0] flow_key;
  logic             valid_flow_key;
  logic             cfg_wr_en;
  logic [IDX_W-1:0] cfg_idx;
  logic [KEY_W-1:0] cfg_key;
  logic [ACT_W-1:0] cfg_action;
  logic             cfg_entry_valid;
  logic             cfg_ack;
  logic             res_valid;
  logic             res_hit;
  logic [ACT_W-1:0] res_action;
  logic [IDX_W-1:0] res_idx;
  logic             init_done;
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;
  logic [31:0]      drop_cnt;

  modport master (
    output flow_key, valid_flow_key, cfg_wr_en, cfg_idx, cfg_key, cfg_action, cfg_entry_valid,
    input  cfg_ack, res_valid, res_hit, res_action, res_idx, init_done, hit_cnt, miss_cnt, drop_cnt
  );
  modport slave (
    input  flow_key, valid_flow_key, cfg_wr_en, cfg_idx, cfg_key, cfg_action, cfg_entry_valid,
    output cfg_ack, res_valid, res_hit, res_action, res_idx, init_done, hit_cnt, miss_cnt, drop_cnt
  );
endinterface

// File: rtl/flow_lookup_ctrl.sv
// Exact-match flow lookup: key FIFO, direct-indexed table shared with a
// config write port, hit/miss result and statistics.
module flow_lookup_ctrl #(
  parameter int KEY_W      = 128,
  parameter int ACT_W      = 16,
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  flow_lookup_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int ENT_W = 1 + KEY_W + ACT_W;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_CFG} state_t;

  // XOR-fold of all IDX_W slices, LSB slice first
  function automatic logic [IDX_W-1:0] hash(input logic [KEY_W-1:0] k);
    logic [IDX_W-1:0] h;
    h = '0;
    for (int i = 0; i < KEY_W / IDX_W; i++) h ^= k[i*IDX_W +: IDX_W];
    return h;
  endfunction

  state_t           state_q;
  logic [IDX_W-1:0] init_cnt_q, idx_q, res_idx_q;
  logic [KEY_W-1:0] key_q;
  logic [ENT_W-1:0] ram [DEPTH];
  logic [ENT_W-1:0] rdata_q;
  logic             last_cfg_q;
  logic             cfg_ack_q, res_valid_q, res_hit_q, init_done_q;
  logic [ACT_W-1:0] res_action_q;
  logic [31:0]      hit_cnt_q, miss_cnt_q, drop_cnt_q;

  logic [KEY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  logic             fifo_empty, fifo_full, push, pop, drop;
  logic             grant_cfg, grant_lk, hit;
  logic [KEY_W-1:0] head_key;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [ENT_W-1:0] ram_wdata;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign head_key   = fifo_mem[rd_ptr_q];

  // Config wins a tie unless it also took the previous grant
  assign grant_cfg = (state_q == S_IDLE) && bus.cfg_wr_en && (fifo_empty || !last_cfg_q);
  assign grant_lk  = (state_q == S_IDLE) && !fifo_empty && !grant_cfg;

  // No backpressure upstream: a full FIFO drops unless a pop frees a slot this cycle
  assign pop  = grant_lk;
  assign push = bus.valid_flow_key && (!fifo_full || pop);
  assign drop = bus.valid_flow_key && !push;

  assign hit = rdata_q[ENT_W-1] && (rdata_q[KEY_W+ACT_W-1:ACT_W] == key_q);

  // Single table port: init sweep and config writes, otherwise lookup read address
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = {bus.cfg_entry_valid, bus.cfg_key, bus.cfg_action};
    case (state_q)
      S_INIT: begin
        ram_we    = !rst;
        ram_addr  = init_cnt_q;
        ram_wdata = '0;
      end
      S_CFG: begin
        ram_we   = !rst;
        ram_addr = bus.cfg_idx;
      end
      default: ;
    endcase
  end

  // Flow table with one-cycle registered read
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    rdata_q <= ram[ram_addr];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.flow_key;
  end

  // FIFO pointers, occupancy and drop statistic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      if (drop) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  // Control FSM with registered result/ack outputs and hit/miss statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      last_cfg_q   <= 1'b0;
      key_q        <= '0;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      cfg_ack_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_action_q <= '0;
      res_idx_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      cfg_ack_q   <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + IDX_W'(1);
          if (init_cnt_q == {IDX_W{1'b1}}) begin
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (grant_cfg) begin
            last_cfg_q <= 1'b1;
            state_q    <= S_CFG;
          end else if (grant_lk) begin
            last_cfg_q <= 1'b0;
            key_q      <= head_key;
            idx_q      <= hash(head_key);
            state_q    <= S_RD;
          end
        end
        S_RD: state_q <= S_CMP;
        S_CMP: begin
          res_valid_q  <= 1'b1;
          res_hit_q    <= hit;
          res_action_q <= hit ? rdata_q[ACT_W-1:0] : '0;
          res_idx_q    <= idx_q;
          if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
          else     miss_cnt_q <= miss_cnt_q + 32'd1;
          state_q <= S_IDLE;
        end
        S_CFG: begin
          cfg_ack_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.cfg_ack    = cfg_ack_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hit    = res_hit_q;
  assign bus.res_action = res_action_q;
  assign bus.res_idx    = res_idx_q;
  assign bus.init_done  = init_done_q;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_flow_lookup_ctrl.sv
// Directed bench for flow_lookup_ctrl: init sweep, config, hit/miss, drops,
// config/lookup alternation and mid-lookup reset.
module tb_flow_lookup_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_n = 0;
  int   err_n = 0;

  flow_lookup_ctrl_if bus ();

  flow_lookup_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    if (obs !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // strobe one key; lat = edges after the sampling edge until res_valid
  task automatic lookup(input logic [127:0] k, output int lat);
    bus.flow_key       = k;
    bus.valid_flow_key = 1'b1;
    tick();
    bus.valid_flow_key = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic cfg_write(input logic [7:0] idx, input logic [127:0] k, input logic [15:0] act,
                           input logic v, output int lat);
    bus.cfg_idx         = idx;
    bus.cfg_key         = k;
    bus.cfg_action      = act;
    bus.cfg_entry_valid = v;
    bus.cfg_wr_en       = 1'b1;
    tick();
    lat = 0;
    while (!bus.cfg_ack && lat < 20) begin
      tick();
      lat++;
    end
    bus.cfg_wr_en = 1'b0;
  endtask

  // count edges from reset release until init_done, watching for stray results
  task automatic wait_init(input string tag);
    int n;
    int rv;
    n  = 0;
    rv = 0;
    while (!bus.init_done && n < 400) begin
      tick();
      n++;
      if (bus.res_valid) rv++;
    end
    chk({tag, "_lat"}, n, 256);
    chk({tag, "_no_res"}, rv, 0);
  endtask

  initial begin
    int lat;
    int nres;
    int nack;
    int nhit;
    logic expect_ack;
    logic [127:0] k;

    bus.flow_key        = '0;
    bus.valid_flow_key  = 1'b0;
    bus.cfg_wr_en       = 1'b0;
    bus.cfg_idx         = '0;
    bus.cfg_key         = '0;
    bus.cfg_action      = '0;
    bus.cfg_entry_valid = 1'b0;

    tick();
    tick();
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cfg_ack",   bus.cfg_ack, 0);
    chk("rst_hit_cnt",   bus.hit_cnt, 0);
    chk("rst_miss_cnt",  bus.miss_cnt, 0);
    chk("rst_drop_cnt",  bus.drop_cnt, 0);
    rst = 1'b0;
    wait_init("init");

    // empty table: miss; upper-byte-only key hashes to that byte
    lookup({8'hA5, 120'h0}, lat);
    chk("miss0_lat", lat, 3);
    chk("miss0_hit", bus.res_hit, 0);
    chk("miss0_act", bus.res_action, 0);
    chk("miss0_idx", bus.res_idx, 32'hA5);
    chk("miss0_cnt", bus.miss_cnt, 1);

    // install entry then hit it
    cfg_write(8'h11, 128'h11, 16'hBEEF, 1'b1, lat);
    chk("cfg_lat", lat, 1);
    tick();
    chk("cfg_ack_pulse", bus.cfg_ack, 0);
    lookup(128'h11, lat);
    chk("hit_lat", lat, 3);
    chk("hit_hit", bus.res_hit, 1);
    chk("hit_act", bus.res_action, 32'hBEEF);
    chk("hit_idx", bus.res_idx, 32'h11);
    chk("hit_cnt", bus.hit_cnt, 1);
    tick();
    chk("res_pulse", bus.res_valid, 0);

    // same index, different key
    lookup({8'h01, 112'h0, 8'h10}, lat);
    chk("alias_lat", lat, 3);
    chk("alias_hit", bus.res_hit, 0);
    chk("alias_act", bus.res_action, 0);
    chk("alias_idx", bus.res_idx, 32'h11);
    chk("alias_miss", bus.miss_cnt, 2);

    // four back-to-back strobes into a 2-deep FIFO
    for (int i = 1; i <= 4; i++) begin
      bus.flow_key       = 128'(i);
      bus.valid_flow_key = 1'b1;
      tick();
    end
    bus.valid_flow_key = 1'b0;
    nres = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) nres++;
      tick();
    end
    chk("burst_results", nres, 3);
    chk("burst_drop", bus.drop_cnt, 1);
    chk("burst_miss", bus.miss_cnt, 5);

    // held delete request vs continuously refilled FIFO: grants must alternate
    bus.cfg_idx         = 8'h11;
    bus.cfg_key         = 128'h11;
    bus.cfg_action      = 16'h0;
    bus.cfg_entry_valid = 1'b0;
    bus.cfg_wr_en       = 1'b1;
    bus.flow_key        = 128'h11;
    bus.valid_flow_key  = 1'b1;
    expect_ack = 1'b1;
    nres = 0;
    nack = 0;
    nhit = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.cfg_ack || bus.res_valid) begin
        chk("alt_order", bus.cfg_ack, expect_ack);
        expect_ack = ~bus.cfg_ack;
      end
      if (bus.cfg_ack) nack++;
      if (bus.res_valid) begin
        nres++;
        if (bus.res_hit) nhit++;
      end
    end
    bus.cfg_wr_en      = 1'b0;
    bus.valid_flow_key = 1'b0;
    chk("alt_lookups", (nres >= 3) ? 1 : 0, 1);
    chk("alt_cfgs", (nack >= 3) ? 1 : 0, 1);
    chk("alt_deleted_hits", nhit, 0);
    for (int i = 0; i < 20; i++) tick();
    lookup(128'h11, lat);
    chk("del_lat", lat, 3);
    chk("del_hit", bus.res_hit, 0);
    chk("del_act", bus.res_action, 0);
    chk("del_hit_cnt", bus.hit_cnt, 1);

    // reset while a lookup is in RD, with a second key queued
    tick();
    bus.flow_key       = 128'h22;
    bus.valid_flow_key = 1'b1;
    tick();
    bus.flow_key = 128'h33;
    tick();
    bus.valid_flow_key = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_init_done", bus.init_done, 0);
    chk("abort_hit_cnt", bus.hit_cnt, 0);
    chk("abort_miss_cnt", bus.miss_cnt, 0);
    chk("abort_drop_cnt", bus.drop_cnt, 0);
    rst = 1'b0;
    wait_init("reinit");
    nres = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid) nres++;
    end
    chk("flushed_fifo", nres, 0);
    chk("flushed_miss", bus.miss_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
    $finish;
  end
endmodule
